// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access / write-back stage.
// Takes one instruction's ALU result, store operand and control, then does one of:
//   - an ALU pass-through, which writes back one cycle later
//   - a load or store to the internal data RAM, which takes MEM_LATENCY cycles
// It produces the write-back triple and a one-deep history of wb_data for forwarding.
// While a memory access is in progress, stall tells upstream to hold its inputs.
module mem_wb_stage #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [2:0]        dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data_prev
);

  // Counter is at least one bit wide, so that MEM_LATENCY=1 still elaborates cleanly.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_data;
  logic [2:0]          op_dest;
  logic                op_load;
  logic [DATA_W-1:0]   ram [2**ADDR_W];
  logic                access_done;
  logic                ram_we;

  // A memory op completes on the edge where the ACCESS countdown has reached zero.
  assign access_done = (state == ACCESS) && (count == '0);
  assign ram_we      = access_done && !op_load;
  assign stall       = (state == ACCESS);

  // Data RAM write port. It has no reset, so contents survive a reset.
  // An aborted store never writes, because reset forces state out of ACCESS.
  always_ff @(posedge clk) begin
    if (ram_we) ram[op_addr] <= op_data;
  end

  // Capture ops, sequence the memory access, and drive the registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      wb_en        <= 1'b0;
      wb_data      <= '0;
      wb_dest      <= '0;
      wb_data_prev <= '0;
      op_addr      <= '0;
      op_data      <= '0;
      op_dest      <= '0;
      op_load      <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_read || mem_write) begin
              state   <= ACCESS;
              count   <= CNT_W'(MEM_LATENCY - 1);
              op_addr <= alu_result[ADDR_W-1:0];
              op_data <= store_data;
              op_dest <= dest_reg;
              op_load <= mem_read && !mem_write;
            end else if (reg_write) begin
              wb_en        <= 1'b1;
              wb_data      <= alu_result;
              wb_dest      <= dest_reg;
              wb_data_prev <= wb_data;
            end
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            state <= IDLE;
            if (op_load) begin
              wb_en        <= 1'b1;
              wb_data      <= ram[op_addr];
              wb_dest      <= op_dest;
              wb_data_prev <= wb_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized scoreboard bench for mem_wb_stage.
// Three instances are built with MEM_LATENCY of 2, 1 and 4, and each is exercised in turn.
// A behavioural model (a RAM array plus the last two write-back values) predicts results.
// Expected write-backs are queued at capture; a monitor pops and compares them on wb_en.
module tb_mem_wb_stage;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dest;
    logic [15:0] prev;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_a  [3];
  logic [15:0] alu_a       [3];
  logic [15:0] sd_a        [3];
  logic [2:0]  dest_a      [3];
  logic        rw_a        [3];
  logic        mr_a        [3];
  logic        mw_a        [3];
  logic        stall_a     [3];
  logic        wb_en_a     [3];
  logic [15:0] wb_data_a   [3];
  logic [2:0]  wb_dest_a   [3];
  logic [15:0] wb_prev_a   [3];

  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  int          lat = 2;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [256];
  logic [15:0] ref_wb;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      mem_wb_stage #(
        .DATA_W(16),
        .ADDR_W(8),
        .MEM_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
      ) u_dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid_a[g]),
        .alu_result(alu_a[g]),
        .store_data(sd_a[g]),
        .dest_reg(dest_a[g]),
        .reg_write(rw_a[g]),
        .mem_read(mr_a[g]),
        .mem_write(mw_a[g]),
        .stall(stall_a[g]),
        .wb_en(wb_en_a[g]),
        .wb_data(wb_data_a[g]),
        .wb_dest(wb_dest_a[g]),
        .wb_data_prev(wb_prev_a[g])
      );
    end
  endgenerate

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s (latency %0d): got %0h, expected %0h", name, lat, act, req);
    end
  endtask

  // Update the model when an op is captured.
  // Stores go to the RAM model; loads and ALU writes queue their expected write-back.
  task automatic model_capture(input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] dest,
                               input logic rw, input logic mr, input logic mw);
    exp_t e;
    if (mw) begin
      ref_mem[alu[7:0]] = sd;
    end else if (mr || rw) begin
      e.data = mr ? ref_mem[alu[7:0]] : alu;
      e.dest = dest;
      e.prev = ref_wb;
      exp_q.push_back(e);
      ref_wb = e.data;
    end
  endtask

  // Issue one op, then count stall cycles.
  // While stalled, random junk (including in_valid pulses) is driven onto the inputs.
  task automatic apply_stimulus(input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] dest,
                                input logic rw, input logic mr, input logic mw);
    int  cnt;
    bit  done;
    @(negedge clk);
    in_valid_a[cur] = 1'b1;
    alu_a[cur] = alu; sd_a[cur] = sd; dest_a[cur] = dest;
    rw_a[cur] = rw; mr_a[cur] = mr; mw_a[cur] = mw;
    @(posedge clk);
    model_capture(alu, sd, dest, rw, mr, mw);
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall_a[cur]) begin
        cnt++;
        in_valid_a[cur] = 1'($urandom_range(0, 1));
        alu_a[cur] = 16'($urandom); sd_a[cur] = 16'($urandom); dest_a[cur] = 3'($urandom);
        rw_a[cur] = 1'($urandom); mr_a[cur] = 1'($urandom); mw_a[cur] = 1'($urandom);
      end else begin
        in_valid_a[cur] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check_output("stall timeout", 32'(done), 1);
    check_output("stall cycles", 32'(cnt), (mr || mw) ? 32'(lat) : 0);
  endtask

  // Start a store, then assert reset mid-cycle in its last ACCESS cycle.
  // All outputs must clear at once, and the RAM must keep its old value.
  task automatic abort_store(input logic [15:0] alu, input logic [15:0] sd);
    @(negedge clk);
    in_valid_a[cur] = 1'b1;
    alu_a[cur] = alu; sd_a[cur] = sd; dest_a[cur] = 3'd0;
    rw_a[cur] = 1'b0; mr_a[cur] = 1'b0; mw_a[cur] = 1'b1;
    @(posedge clk);
    #1 in_valid_a[cur] = 1'b0;
    repeat (lat - 1) @(posedge clk);
    #2;
    check_output("stall before abort", 32'(stall_a[cur]), 1);
    reset = 1'b1;
    #1;
    check_output("abort stall", 32'(stall_a[cur]), 0);
    check_output("abort wb_en", 32'(wb_en_a[cur]), 0);
    check_output("abort wb_data", 32'(wb_data_a[cur]), 0);
    check_output("abort wb_dest", 32'(wb_dest_a[cur]), 0);
    check_output("abort wb_data_prev", 32'(wb_prev_a[cur]), 0);
    exp_q.delete();
    ref_wb = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: each wb_en pulse on the active instance must match the oldest expectation.
  // The idle instances must never pulse wb_en.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        if (i != cur && wb_en_a[i]) check_output("idle instance wb_en", 32'(wb_en_a[i]), 0);
      if (wb_en_a[cur]) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected wb_en", 32'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("wb_data", 32'(wb_data_a[cur]), 32'(mon_e.data));
          check_output("wb_dest", 32'(wb_dest_a[cur]), 32'(mon_e.dest));
          check_output("wb_data_prev", 32'(wb_prev_a[cur]), 32'(mon_e.prev));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, then directed and random ops for each latency.
  initial begin
    logic [15:0] a;
    logic [2:0]  kind;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0; alu_a[i] = '0; sd_a[i] = '0; dest_a[i] = '0;
      rw_a[i] = 1'b0; mr_a[i] = 1'b0; mw_a[i] = 1'b0;
    end
    #12;
    check_output("reset stall", 32'(stall_a[0]), 0);
    check_output("reset wb_en", 32'(wb_en_a[0]), 0);
    check_output("reset wb_data", 32'(wb_data_a[0]), 0);
    check_output("reset wb_dest", 32'(wb_dest_a[0]), 0);
    check_output("reset wb_data_prev", 32'(wb_prev_a[0]), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int p = 0; p < 3; p++) begin
      cur = p;
      lat = (p == 0) ? 2 : ((p == 1) ? 1 : 4);
      ref_wb = '0;
      $display("[TB] phase with MEM_LATENCY=%0d", lat);
      for (int i = 0; i < 16; i++)
        apply_stimulus(16'(i), 16'($urandom), 3'd0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0);
      apply_stimulus(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(16'h0010, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0);
      apply_stimulus(16'h0110, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0);
      apply_stimulus(16'h0020, 16'h1111, 3'd0, 1'b0, 1'b0, 1'b1);
      abort_store(16'h0020, 16'h5555);
      apply_stimulus(16'h0020, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0);
      apply_stimulus(16'h0030, 16'h7777, 3'd4, 1'b1, 1'b1, 1'b1);
      apply_stimulus(16'h0030, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 40; n++) begin
        kind = 3'($urandom_range(0, 4));
        a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
        case (kind)
          3'd0:    apply_stimulus(16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b0);
          3'd1:    apply_stimulus(16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
          3'd2:    apply_stimulus(a, 16'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b0);
          3'd3:    apply_stimulus(a, 16'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'b1);
          default: apply_stimulus(a, 16'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b1);
        endcase
      end
      repeat (3) @(negedge clk);
      check_output("pending write-backs", 32'(exp_q.size()), 0);
      check_output("final wb_data", 32'(wb_data_a[cur]), 32'(ref_wb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
